// File: rtl/simd_seq_ctrl.sv
// Operand sequencer for the SIMD unit: buffers host bytes, streams them in on a run,
// holds send for a fixed window and returns the captured result nibbles.
module simd_seq_ctrl #(
    parameter int unsigned NBYTES       = 32,
    parameter int unsigned SETUP_CYCLES = 3,
    parameter int unsigned SEND_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       clr_buf,
    output logic       wr_full,
    input  logic       start,
    input  logic [3:0] start_mode,
    input  logic       start_dtype,
    input  logic       start_reuse,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       load,
    output logic [3:0] mode,
    output logic       dtype,
    output logic [7:0] data_,
    output logic       send,
    input  logic [3:0] simd_data,
    output logic       res_valid,
    output logic [3:0] res_data
);

    localparam int unsigned MaxLs    = (NBYTES > SETUP_CYCLES) ? NBYTES : SETUP_CYCLES;
    localparam int unsigned MaxPhase = (MaxLs > SEND_CYCLES) ? MaxLs : SEND_CYCLES;
    localparam int unsigned CntW     = $clog2(MaxPhase + 1);
    localparam int unsigned PtrW     = $clog2(NBYTES + 1);
    localparam int unsigned IdxW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {StIdle, StLoad, StSetup, StSend, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic              loaded_q, loaded_d;
    logic              err_d, accept, buf_we, full;
    logic [7:0]        buf_mem [NBYTES];

    logic       wr_full_q, busy_q, done_q, err_q, load_q, dtype_q, send_q, res_valid_q;
    logic [3:0] mode_q, res_data_q;
    logic [7:0] data_q;

    assign full = (wr_ptr_q == PtrW'(NBYTES));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        loaded_d = loaded_q;
        err_d    = 1'b0;
        accept   = 1'b0;
        buf_we   = 1'b0;

        // busy_q also covers the done cycle, so host requests there are rejected too
        if (!busy_q) begin
            if (clr_buf) begin
                wr_ptr_d = '0;
                loaded_d = 1'b0;
            end else if (wr_en) begin
                if (full) begin
                    err_d = 1'b1;
                end else begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PtrW'(1);
                end
            end
            if (start) begin
                if (!start_reuse && full) begin
                    accept  = 1'b1;
                    state_d = StLoad;
                end else if (start_reuse && loaded_q) begin
                    accept  = 1'b1;
                    state_d = StSetup;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (wr_en || clr_buf || start) begin
            err_d = 1'b1;
        end

        case (state_q)
            StLoad: begin
                if (cnt_q == CntW'(NBYTES - 1)) begin
                    cnt_d    = '0;
                    loaded_d = 1'b1;
                    state_d  = StSetup;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StSetup: begin
                if (cnt_q == CntW'(SETUP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StSend;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StSend: begin
                if (cnt_q == CntW'(SEND_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: ;
        endcase
    end

    // Operand storage needs no reset: an empty buffer is defined by wr_ptr alone
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[wr_ptr_q[IdxW-1:0]] <= wr_data;
        end
    end

    // Outputs are registered decodes of the current phase, one cycle behind it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            loaded_q    <= 1'b0;
            wr_full_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            load_q      <= 1'b0;
            mode_q      <= '0;
            dtype_q     <= 1'b0;
            data_q      <= '0;
            send_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            loaded_q    <= loaded_d;
            wr_full_q   <= (wr_ptr_d == PtrW'(NBYTES));
            busy_q      <= (state_d != StIdle) || (state_q == StDone);
            done_q      <= (state_q == StDone);
            err_q       <= err_d;
            load_q      <= (state_q == StLoad);
            send_q      <= (state_q == StSend);
            res_valid_q <= send_q;
            if (state_q == StLoad) begin
                data_q <= buf_mem[cnt_q[IdxW-1:0]];
            end
            if (send_q) begin
                res_data_q <= simd_data;
            end
            if (accept) begin
                mode_q  <= start_mode;
                dtype_q <= start_dtype;
            end
        end
    end

    assign wr_full   = wr_full_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign load      = load_q;
    assign mode      = mode_q;
    assign dtype     = dtype_q;
    assign data_     = data_q;
    assign send      = send_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_simd_seq_ctrl.sv
// Scoreboard bench for simd_seq_ctrl: a transaction-level model predicts every output event
// by cycle number; a negedge monitor pops and compares them as the DUT produces them.
module tb_simd_seq_ctrl;

    localparam int NB    = 32;
    localparam int SETUP = 3;
    localparam int SEND  = 16;
    localparam int TAB   = 8192;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_buf;
    logic       wr_full;
    logic       start;
    logic [3:0] start_mode;
    logic       start_dtype;
    logic       start_reuse;
    logic       busy;
    logic       done;
    logic       err;
    logic       load;
    logic [3:0] mode;
    logic       dtype;
    logic [7:0] data_;
    logic       send;
    logic [3:0] simd_data;
    logic       res_valid;
    logic [3:0] res_data;

    simd_seq_ctrl #(
        .NBYTES      (NB),
        .SETUP_CYCLES(SETUP),
        .SEND_CYCLES (SEND)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .clr_buf    (clr_buf),
        .wr_full    (wr_full),
        .start      (start),
        .start_mode (start_mode),
        .start_dtype(start_dtype),
        .start_reuse(start_reuse),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .load       (load),
        .mode       (mode),
        .dtype      (dtype),
        .data_      (data_),
        .send       (send),
        .simd_data  (simd_data),
        .res_valid  (res_valid),
        .res_data   (res_data)
    );

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 0;
    logic [3:0] sd_tab [TAB];

    // Model state: bytes the host has written, operand residency, current run window
    logic [7:0] mbytes [$];
    bit         mloaded;
    int         run_s;
    int         run_done;
    logic [3:0] exp_mode;
    logic       exp_dtype;
    // Expected events: 0 load/data_, 1 send, 2 res_valid/res_data, 3 done, 4 err
    ev_t        evq [5][$];

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        #1;
        simd_data = sd_tab[cyc % TAB];
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic mon_stream(input int id, input string nm, input logic sig, input int val);
        ev_t e;
        if (sig) begin
            if (evq[id].size() == 0) begin
                chk({nm, "_spurious"}, int'(sig), 0);
            end else begin
                e = evq[id].pop_front();
                chk({nm, "_cycle"}, cyc, e.cyc);
                chk({nm, "_value"}, val, e.val);
            end
        end else if (evq[id].size() > 0 && evq[id][0].cyc <= cyc) begin
            e = evq[id].pop_front();
            chk({nm, "_missing"}, int'(sig), 1);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", int'(busy), int'(cyc >= run_s && cyc <= run_done));
            chk("wr_full", int'(wr_full), int'(mbytes.size() == NB));
            chk("mode", int'(mode), int'(exp_mode));
            chk("dtype", int'(dtype), int'(exp_dtype));
            mon_stream(0, "load", load, int'(data_));
            mon_stream(1, "send", send, 0);
            mon_stream(2, "res", res_valid, int'(res_data));
            mon_stream(3, "done", done, 0);
            mon_stream(4, "err", err, 0);
        end
    end

    // A run accepted at edge s: operands stream from s+1, send follows load and setup,
    // each nibble appears the cycle after its send cycle, done with the last nibble.
    task automatic launch(input int s, input bit reuse, input logic [3:0] m, input logic dt);
        int pre;
        pre = reuse ? SETUP : NB + SETUP;
        if (!reuse) begin
            foreach (mbytes[i]) evq[0].push_back('{s + 1 + i, int'(mbytes[i])});
        end
        for (int j = 0; j < SEND; j++) begin
            evq[1].push_back('{s + pre + 1 + j, 0});
            evq[2].push_back('{s + pre + 2 + j, int'(sd_tab[(s + pre + 1 + j) % TAB])});
        end
        evq[3].push_back('{s + pre + SEND + 1, 0});
        run_s     = s;
        run_done  = s + pre + SEND + 1;
        exp_mode  = m;
        exp_dtype = dt;
    endtask

    task automatic drive(input bit w, input logic [7:0] d, input bit c, input bit st,
                         input logic [3:0] m, input bit dt, input bit ru, input bit r);
        int k;
        bit bsy, full_before, loaded_before, e;
        @(negedge clk);
        #1;
        wr_en = w; wr_data = d; clr_buf = c; start = st;
        start_mode = m; start_dtype = dt; start_reuse = ru; rst = r;
        k = cyc;
        if (r) begin
            for (int i = 0; i < 5; i++) begin
                while (evq[i].size() > 0 && evq[i][$].cyc > k) void'(evq[i].pop_back());
            end
            mbytes.delete();
            mloaded   = 0;
            exp_mode  = 0;
            exp_dtype = 0;
            if (run_done > k) run_done = k;
        end else begin
            bsy           = (k >= run_s && k <= run_done);
            full_before   = (mbytes.size() == NB);
            loaded_before = mloaded;
            e             = 0;
            if (bsy) begin
                e = w || c || st;
            end else begin
                if (c) begin
                    mbytes.delete();
                    mloaded = 0;
                end else if (w) begin
                    if (full_before) e = 1;
                    else mbytes.push_back(d);
                end
                if (st) begin
                    if (!ru && full_before) begin
                        launch(k + 1, 0, m, dt);
                        mloaded = 1;
                    end else if (ru && loaded_before) begin
                        launch(k + 1, 1, m, dt);
                    end else begin
                        e = 1;
                    end
                end
            end
            if (e) evq[4].push_back('{k + 1, 0});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 8'h00, 0, 0, 4'h0, 0, 0, 0);
    endtask

    task automatic wr(input logic [7:0] d);
        drive(1, d, 0, 0, 4'h0, 0, 0, 0);
    endtask

    task automatic go(input logic [3:0] m, input bit dt, input bit ru);
        drive(0, 8'h00, 0, 1, m, dt, ru, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cyc < run_done && n < 400) begin
            idle(1);
            n++;
        end
        chk("run_finished", int'(cyc >= run_done), 1);
    endtask

    task automatic chk_cleared();
        chk("data_after_reset", int'(data_), 0);
        chk("res_data_after_reset", int'(res_data), 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0] vec [NB];
        int r;
        for (int i = 0; i < TAB; i++) sd_tab[i] = 4'($urandom);
        for (int i = 0; i < 16; i++) vec[i] = 8'($urandom);
        vec[0] = 8'ha1; vec[1] = 8'h13; vec[2] = 8'h3d;
        for (int i = 0; i < 15; i++) vec[16 + i] = 8'ha1 + 8'(i * 4);
        vec[31] = 8'h57;
        rst = 1; wr_en = 0; wr_data = 0; clr_buf = 0; start = 0;
        start_mode = 0; start_dtype = 0; start_reuse = 0; simd_data = 0;
        mloaded = 0; run_s = 0; run_done = -1; exp_mode = 0; exp_dtype = 0;

        repeat (3) drive(0, 8'h00, 0, 0, 4'h0, 0, 0, 1);
        mon_en = 1;
        idle(1);
        chk_cleared();

        // Reuse with nothing resident, then a start one byte short of full
        go(4'h5, 1, 1);
        idle(2);
        for (int i = 0; i < NB - 1; i++) wr(vec[i]);
        go(4'h0, 0, 0);
        idle(2);
        wr(vec[NB - 1]);
        wr(8'hee);
        idle(2);

        // Full load run, then reuse runs with new modes
        go(4'h0, 0, 0);
        wait_idle();
        for (int m = 1; m <= 3; m++) begin
            go(4'(m), 1'(m), 1);
            wait_idle();
        end

        // Host traffic during SEND is refused and leaves the run intact
        go(4'h4, 0, 1);
        idle(5);
        wr(8'h11);
        drive(0, 8'h00, 1, 0, 4'h0, 0, 0, 0);
        go(4'h7, 1, 0);
        wait_idle();
        go(4'h9, 1, 0);
        wait_idle();

        // Reset mid-LOAD, then reuse must be refused
        go(4'h6, 1, 0);
        idle(10);
        drive(0, 8'h00, 0, 0, 4'h0, 0, 0, 1);
        idle(1);
        chk_cleared();
        go(4'h2, 0, 1);
        idle(2);

        // Reset mid-SEND
        for (int i = 0; i < NB; i++) wr(8'($urandom));
        go(4'hc, 0, 0);
        idle(NB + SETUP + 5);
        drive(0, 8'h00, 0, 0, 4'h0, 0, 0, 1);
        idle(1);
        chk_cleared();

        // Write and clear together: clear wins silently, then a fresh full buffer
        for (int i = 0; i < 10; i++) wr(8'($urandom));
        drive(1, 8'h99, 1, 0, 4'h0, 0, 0, 0);
        for (int i = 0; i < NB; i++) wr(8'($urandom));
        go(4'hb, 0, 0);
        wait_idle();

        // Random traffic against the model
        for (int n = 0; n < 900; n++) begin
            r = $urandom_range(0, 199);
            if (r == 0) drive(0, 8'h00, 0, 0, 4'h0, 0, 0, 1);
            else if (r < 3) drive(0, 8'h00, 1, 0, 4'h0, 0, 0, 0);
            else if (r == 3) drive(1, 8'($urandom), 1, 0, 4'h0, 0, 0, 0);
            else if (r < 14) go(4'($urandom), 1'($urandom), 1'($urandom));
            else if (r < 90) wr(8'($urandom));
            else idle(1);
        end
        wait_idle();
        idle(3);

        for (int i = 0; i < 5; i++) chk("events_left", evq[i].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
